// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Reused by the CPU-side request logic.
package data_mem_responder_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_byte_array.sv
// DEPTH x 32 storage, byte-lane write port,
// registered read port with a clear for error/write responses.
module mem_byte_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  input  logic [AW-1:0]         addr,
  input  logic [MEM_DATA_W-1:0] wdata,
  input  logic [MEM_BE_W-1:0]   be,
  output logic [MEM_DATA_W-1:0] rdata
);

  logic [MEM_DATA_W-1:0] mem_q [DEPTH];
  logic [MEM_DATA_W-1:0] rdata_q;
  logic [MEM_DATA_W-1:0] rdata_d;

  // byte-lane write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MEM_BE_W; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // read data only changes on a commit
  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  // read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request in flight,
// fixed access latency, valid/ready on both sides.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_W-1:0]     ReqAddr,
  input  logic [MEM_DATA_W-1:0] ReqWData,
  input  logic [MEM_BE_W-1:0]   ReqByteEn,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [MEM_DATA_W-1:0] RspRData,
  output logic                  RspError,
  output logic                  Busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  mem_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [MEM_BE_W-1:0] be_q, be_d;
  logic err_q, err_d;
  logic commit;
  logic in_range;
  logic arr_we, arr_re, arr_clr;

  // next state, capture and commit strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ReqValid && !Reset) begin
          wr_d    = ReqWrite;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          be_d    = ReqByteEn;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (RspReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (Reset) begin
      commit = 1'b0;
    end
    in_range = {1'b0, addr_d} < DEPTH_C;
    if (commit) begin
      err_d = !in_range;
    end
  end

  // FSM, counter and captured request
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  assign arr_we  = commit && wr_d && in_range;
  assign arr_re  = commit && !wr_d && in_range;
  assign arr_clr = commit && (wr_d || !in_range);

  mem_byte_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_arr (
    .clk   (Clk),
    .rst   (Reset),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .addr  (addr_d[AW-1:0]),
    .wdata (wdata_d),
    .be    (be_d),
    .rdata (RspRData)
  );

  assign ReqReady = (state_q == IDLE) && !Reset;
  assign RspValid = (state_q == RESP) && !Reset;
  assign RspError = err_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at
// LATENCY=2 (sel=0) and LATENCY=1 (sel=1).
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic req_valid;
  logic req_write;
  logic [9:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0] req_be;
  logic rsp_ready;

  logic rr0, rv0, re0, b0;
  logic rr1, rv1, re1, b1;
  logic [31:0] rd0, rd1;

  logic req_ready, rsp_valid, rsp_error, busy;
  logic [31:0] rsp_rdata;

  int vecs = 0;
  int fails = 0;
  int cyc = 0;
  int nrsp = 0;

  typedef struct {
    bit          sel;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] ed;
    logic        ee;
    int          acc;
  } txn_t;

  txn_t q[$];
  logic [31:0] mdl [2][512];
  bit lat_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(
    .ADDR_W(10), .DEPTH(512), .LATENCY(2)
  ) dut0 (
    .Clk(clk), .Reset(rst),
    .ReqValid(req_valid && !sel), .ReqReady(rr0),
    .ReqWrite(req_write), .ReqAddr(req_addr),
    .ReqWData(req_wdata), .ReqByteEn(req_be),
    .RspValid(rv0), .RspReady(rsp_ready),
    .RspRData(rd0), .RspError(re0), .Busy(b0)
  );

  data_mem_responder #(
    .ADDR_W(10), .DEPTH(512), .LATENCY(1)
  ) dut1 (
    .Clk(clk), .Reset(rst),
    .ReqValid(req_valid && sel), .ReqReady(rr1),
    .ReqWrite(req_write), .ReqAddr(req_addr),
    .ReqWData(req_wdata), .ReqByteEn(req_be),
    .RspValid(rv1), .RspReady(rsp_ready),
    .RspRData(rd1), .RspError(re1), .Busy(b1)
  );

  assign req_ready = sel ? rr1 : rr0;
  assign rsp_valid = sel ? rv1 : rv0;
  assign rsp_rdata = sel ? rd1 : rd0;
  assign rsp_error = sel ? re1 : re0;
  assign busy      = sel ? b1 : b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: push on acceptance, pop on response handshake
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      lat_done = 0;
    end else begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexp_rsp", {31'b0, rsp_valid}, 32'd0);
        end else begin
          if (!lat_done) begin
            chk("latency", cyc - q[0].acc, q[0].sel ? 1 : 2);
            lat_done = 1;
          end
          chk("rdata", rsp_rdata, q[0].ed);
          chk("rerr", {31'b0, rsp_error}, {31'b0, q[0].ee});
          chk("rsp_reqrdy", {31'b0, req_ready}, 32'd0);
          if (rsp_ready) begin
            if (q[0].wr && q[0].addr < 10'd512) begin
              for (int b = 0; b < 4; b++) begin
                if (q[0].be[b]) begin
                  mdl[q[0].sel][q[0].addr[8:0]][8*b +: 8] =
                    q[0].wdata[8*b +: 8];
                end
              end
            end
            void'(q.pop_front());
            lat_done = 0;
            nrsp++;
          end
        end
      end
      if (req_valid && req_ready) begin
        txn_t t;
        t.sel   = sel;
        t.wr    = req_write;
        t.addr  = req_addr;
        t.wdata = req_wdata;
        t.be    = req_be;
        t.ee    = !(req_addr < 10'd512);
        t.ed    = (req_write || t.ee) ? 32'd0
                                      : mdl[sel][req_addr[8:0]];
        t.acc   = cyc;
        q.push_back(t);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic w, logic [9:0] a,
                       logic [31:0] d, logic [3:0] be);
    bit ok = 0;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    req_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic txn(logic w, logic [9:0] a,
                     logic [31:0] d, logic [3:0] be);
    issue(w, a, d, be);
    wait_done();
  endtask

  task automatic chk_idle_zero(string tag);
    chk({tag, "_rr"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_rv"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rd"}, rsp_rdata, 32'd0);
    chk({tag, "_re"}, {31'b0, rsp_error}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int prev;
    int base;
    bit ok;
    rst = 1'b1;
    sel = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    rsp_ready = 1'b1;

    // reset held two cycles
    repeat (2) tick();
    chk_idle_zero("rst");
    rst = 1'b0;
    tick();
    chk("rel_rr", {31'b0, req_ready}, 32'd1);

    // known contents everywhere
    for (int i = 0; i < 512; i++) begin
      txn(1'b1, 10'(i), 32'hC0DE0000 | 32'(i), 4'hF);
    end

    // reset while the write is in WAIT
    issue(1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) tick();
    chk_idle_zero("mid");
    rst = 1'b0;
    tick();
    chk("mid_rr", {31'b0, req_ready}, 32'd1);
    repeat (3) begin
      tick();
      chk("mid_norsp", {31'b0, rsp_valid}, 32'd0);
    end
    txn(1'b0, 10'd5, 32'd0, 4'h0);
    chk("mid_old", mdl[0][5], 32'hC0DE0005);

    // full write, read back
    txn(1'b1, 10'd3, 32'h12345678, 4'hF);
    txn(1'b0, 10'd3, 32'd0, 4'h0);

    // byte enables
    txn(1'b1, 10'd3, 32'hAABBCCDD, 4'b0101);
    txn(1'b0, 10'd3, 32'd0, 4'h0);
    chk("be_mdl", mdl[0][3], 32'h12BB56DD);
    txn(1'b1, 10'd3, 32'hFFFFFFFF, 4'b0000);
    txn(1'b0, 10'd3, 32'd0, 4'h0);

    // response backpressure
    rsp_ready = 1'b0;
    issue(1'b0, 10'd3, 32'd0, 4'h0);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("bp_timeout", 32'd0, 32'd1);
    repeat (5) @(negedge clk);
    chk("bp_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done();
    chk("bp_rr", {31'b0, req_ready}, 32'd1);
    chk("bp_idle", {31'b0, busy}, 32'd0);

    // out of range
    txn(1'b0, 10'd512, 32'd0, 4'h0);
    txn(1'b1, 10'd1023, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 512; i++) begin
      txn(1'b0, 10'(i), 32'd0, 4'h0);
    end
    chk("oor_511", mdl[0][511], 32'hC0DE01FF);

    // LATENCY=1 back-to-back
    sel = 1'b1;
    tick();
    base = nrsp;
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      req_write = (i < 8);
      req_addr  = 10'(100 + (i % 8));
      req_wdata = (i < 8) ? $urandom : 32'd0;
      req_be    = 4'hF;
      req_valid = 1'b1;
      ok = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (req_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) chk("b2b_timeout", 32'd0, 32'd1);
      if (i > 0) chk("b2b_period", cyc - prev, 32'd2);
      prev = cyc;
      tick();
    end
    req_valid = 1'b0;
    wait_done();
    chk("b2b_count", nrsp - base, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule
